ubtb_update_gen: RTL and testbench

//  Producer side of the uBTB training interface. Accepts resolved/committed branch records from the

---
 rtl/ubtb_update_gen_if.sv | 59 +++++
 rtl/ubtb_update_gen.sv | 102 ++++++++++
 tb/tb_ubtb_update_gen.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ubtb_update_gen_if.sv
// Shared types and the commit/update port bundle for ubtb_update_gen.
// BRHISTORYLENGTH falls back to 8 when the surrounding build does not set it.
`ifndef BRHISTORYLENGTH
`define BRHISTORYLENGTH 8
`endif

package ubtb_pkg;
  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    isNone = 3'd0,
    isCond = 3'd1,
    isJal  = 3'd2,
    isJalr = 3'd3,
    isCall = 3'd4,
    isRet  = 3'd5
  } BranchType_t;

  typedef struct packed {
    logic            hit;
    logic            taken;
    logic [XLEN-1:0] fallthruAddr;
    logic [XLEN-1:0] targetAddr;
    logic [XLEN-1:0] nextAddr;
    BranchType_t     branch_type;
  } uBTBInfo_t;
endpackage

interface ubtb_update_gen_if #(parameter int GBH_LEN = `BRHISTORYLENGTH);
  import ubtb_pkg::*;

  logic               i_commit_vld;
  logic               o_commit_rdy;
  logic [XLEN-1:0]    i_commit_pc;
  logic [XLEN-1:0]    i_commit_fallthru;
  logic [XLEN-1:0]    i_commit_target;
  logic               i_commit_taken;
  BranchType_t        i_commit_type;
  logic               i_commit_pred_ok;
  logic               i_upd_stall;
  logic               i_flush;
  logic               o_update;
  logic [XLEN-1:0]    o_update_pc;
  logic [GBH_LEN-1:0] o_arch_gbh;
  uBTBInfo_t          o_updateInfo;

  // Commit side drives records and control; the update generator answers.
  modport master (
    output i_commit_vld, i_commit_pc, i_commit_fallthru, i_commit_target,
           i_commit_taken, i_commit_type, i_commit_pred_ok, i_upd_stall, i_flush,
    input  o_commit_rdy, o_update, o_update_pc, o_arch_gbh, o_updateInfo
  );

  modport slave (
    input  i_commit_vld, i_commit_pc, i_commit_fallthru, i_commit_target,
           i_commit_taken, i_commit_type, i_commit_pred_ok, i_upd_stall, i_flush,
    output o_commit_rdy, o_update, o_update_pc, o_arch_gbh, o_updateInfo
  );
endinterface

// File: rtl/ubtb_update_gen.sv
// Buffers committed branch records, tracks architectural GBH, and drains one uBTB update per cycle.
// Optional macro UBTB_UPD_FILTER_EN: skip storing correctly-predicted non-conditional records.
module ubtb_update_gen
  import ubtb_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int GBH_LEN = `BRHISTORYLENGTH
) (
  input logic clk,
  input logic rst,
  ubtb_update_gen_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    fallthru;
    logic [XLEN-1:0]    target;
    logic               taken;
    BranchType_t        btype;
    logic [GBH_LEN-1:0] gbh;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [AW:0]        r_wrPtr;
  logic [AW:0]        r_rdPtr;
  logic [GBH_LEN-1:0] r_gbh;

  logic   w_full;
  logic   w_empty;
  logic   w_accept;
  logic   w_store;
  logic   w_pop;
  logic   w_takenEff;
  logic   w_isCond;
  entry_t w_head;

  assign w_full     = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_empty    = (r_wrPtr == r_rdPtr);
  assign w_accept   = bus.i_commit_vld && !w_full && !bus.i_flush;
  assign w_isCond   = (bus.i_commit_type == isCond);
  assign w_takenEff = (bus.i_commit_type > isCond) ? 1'b1 : bus.i_commit_taken;
  // A record being flushed away is not sent, so flush also masks the strobe.
  assign w_pop      = !w_empty && !bus.i_upd_stall && !bus.i_flush;

`ifdef UBTB_UPD_FILTER_EN
  // Correct non-conditional predictions carry no new information for the uBTB.
  assign w_store = w_accept && !(bus.i_commit_pred_ok && !w_isCond);
`else
  logic w_unused_predOk;
  assign w_unused_predOk = bus.i_commit_pred_ok;
  assign w_store = w_accept;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_gbh   <= '0;
    end else if (bus.i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_store) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)   r_rdPtr <= r_rdPtr + 1'b1;
      if (w_accept && w_isCond) r_gbh <= {r_gbh[GBH_LEN-2:0], w_takenEff};
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[r_wrPtr[AW-1:0]] <= '{pc:       bus.i_commit_pc,
                                  fallthru: bus.i_commit_fallthru,
                                  target:   bus.i_commit_target,
                                  taken:    w_takenEff,
                                  btype:    bus.i_commit_type,
                                  gbh:      r_gbh};
    end
  end

  assign w_head           = r_mem[r_rdPtr[AW-1:0]];
  assign bus.o_commit_rdy = !w_full;
  assign bus.o_update     = w_pop;

  always_comb begin
    bus.o_update_pc  = '0;
    bus.o_arch_gbh   = '0;
    bus.o_updateInfo = '0;
    if (w_pop) begin
      bus.o_update_pc               = w_head.pc;
      bus.o_arch_gbh                = w_head.gbh;
      bus.o_updateInfo.hit          = 1'b1;
      bus.o_updateInfo.taken        = w_head.taken;
      bus.o_updateInfo.fallthruAddr = w_head.fallthru;
      bus.o_updateInfo.targetAddr   = w_head.target;
      bus.o_updateInfo.nextAddr     = w_head.taken ? w_head.target : w_head.fallthru;
      bus.o_updateInfo.branch_type  = w_head.btype;
    end
  end

endmodule

// File: tb/tb_ubtb_update_gen.sv
// Scoreboard bench for ubtb_update_gen: stimulus queues hand-computed packets, a monitor pops and compares.
module tb_ubtb_update_gen;
  import ubtb_pkg::*;

`ifdef UBTB_UPD_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [7:0]  gbh;
    uBTBInfo_t   info;
  } expItem_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  expItem_t expQ[$];

  ubtb_update_gen_if #(.GBH_LEN(8)) bus();

  ubtb_update_gen #(.DEPTH(4), .GBH_LEN(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every update strobe must match the oldest expected packet; idle cycles must show zeros.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_update) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_update", 1, 0);
        end else begin
          expItem_t e;
          e = expQ.pop_front();
          checkOutput("upd_pc", bus.o_update_pc, e.pc);
          checkOutput("upd_gbh", bus.o_arch_gbh, e.gbh);
          checkOutput("upd_info", bus.o_updateInfo, e.info);
        end
      end else begin
        checkOutput("idle_fields", {bus.o_update_pc, bus.o_arch_gbh, bus.o_updateInfo}, 0);
      end
    end
  end

  // Called at posedge+1; holds vld until the handshake completes or the bound expires.
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] ft, input logic [31:0] tgt,
                               input logic taken, input BranchType_t bt, input logic predOk,
                               input logic [7:0] expGbh, input logic expTaken,
                               input logic [31:0] expNext, input bit expEnq);
    expItem_t e;
    int n = 0;
    e.pc   = pc;
    e.gbh  = expGbh;
    e.info = '{hit: 1'b1, taken: expTaken, fallthruAddr: ft, targetAddr: tgt,
               nextAddr: expNext, branch_type: bt};
    if (expEnq) expQ.push_back(e);
    bus.i_commit_pc       = pc;
    bus.i_commit_fallthru = ft;
    bus.i_commit_target   = tgt;
    bus.i_commit_taken    = taken;
    bus.i_commit_type     = bt;
    bus.i_commit_pred_ok  = predOk;
    bus.i_commit_vld      = 1'b1;
    while (!bus.o_commit_rdy && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 30) begin
      checkOutput("handshake_timeout", 1, 0);
      if (expEnq) void'(expQ.pop_back());
    end else begin
      @(posedge clk); #1;
    end
    bus.i_commit_vld = 1'b0;
  endtask

  task automatic waitDrain;
    int n = 0;
    while (expQ.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain_left", expQ.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.i_commit_vld      = 1'b0;
    bus.i_commit_pc       = '0;
    bus.i_commit_fallthru = '0;
    bus.i_commit_target   = '0;
    bus.i_commit_taken    = 1'b0;
    bus.i_commit_type     = isNone;
    bus.i_commit_pred_ok  = 1'b0;
    bus.i_upd_stall       = 1'b0;
    bus.i_flush           = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_update", bus.o_update, 0);
    checkOutput("rst_rdy", bus.o_commit_rdy, 1);
    checkOutput("rst_gbh", bus.o_arch_gbh, 0);
    checkOutput("rst_info", bus.o_updateInfo, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // First cond record: not visible in its own cycle, visible in the next one
    fork
      applyStimulus(32'h8000_0100, 32'h8000_0110, 32'h8000_0040, 1'b1, isCond, 1'b0,
                    8'h00, 1'b1, 32'h8000_0040, 1'b1);
      begin @(negedge clk); checkOutput("no_comb_path", bus.o_update, 0); end
    join
    checkOutput("latency_update", bus.o_update, 1);
    applyStimulus(32'h8000_0200, 32'h8000_0210, 32'h8000_0300, 1'b0, isCond, 1'b0,
                  8'h01, 1'b0, 32'h8000_0210, 1'b1);
    // Non-cond record forced taken, GBH untouched (seen by the following cond record)
    applyStimulus(32'h8000_0400, 32'h8000_0404, 32'h8000_0800, 1'b0, isJal, 1'b0,
                  8'h02, 1'b1, 32'h8000_0800, 1'b1);
    applyStimulus(32'h8000_0500, 32'h8000_0504, 32'h8000_0600, 1'b1, isCond, 1'b0,
                  8'h02, 1'b1, 32'h8000_0600, 1'b1);
    waitDrain();

    // Fill under stall, fifth record held until the first pop
    bus.i_upd_stall = 1'b1;
    applyStimulus(32'h1000, 32'h1004, 32'h2000, 1'b1, isCond, 1'b0, 8'h05, 1'b1, 32'h2000, 1'b1);
    applyStimulus(32'h1100, 32'h1104, 32'h2100, 1'b0, isCond, 1'b0, 8'h0B, 1'b0, 32'h1104, 1'b1);
    applyStimulus(32'h1200, 32'h1204, 32'h2200, 1'b1, isCond, 1'b0, 8'h16, 1'b1, 32'h2200, 1'b1);
    applyStimulus(32'h1300, 32'h1304, 32'h2300, 1'b1, isCond, 1'b0, 8'h2D, 1'b1, 32'h2300, 1'b1);
    checkOutput("full_rdy", bus.o_commit_rdy, 0);
    checkOutput("stall_update", bus.o_update, 0);
    fork
      applyStimulus(32'h1400, 32'h1404, 32'h2400, 1'b0, isCond, 1'b0, 8'h5B, 1'b0, 32'h1404, 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("held_rdy", bus.o_commit_rdy, 0);
        bus.i_upd_stall = 1'b0;
      end
    join
    waitDrain();

    // Flush with a concurrent record while two are buffered under stall
    bus.i_upd_stall = 1'b1;
    applyStimulus(32'h3000, 32'h3004, 32'h3100, 1'b1, isCond, 1'b0, 8'hB6, 1'b1, 32'h3100, 1'b1);
    applyStimulus(32'h3200, 32'h3204, 32'h3300, 1'b1, isCond, 1'b0, 8'h6D, 1'b1, 32'h3300, 1'b1);
    bus.i_commit_pc    = 32'h3400;
    bus.i_commit_type  = isCond;
    bus.i_commit_taken = 1'b1;
    bus.i_commit_vld   = 1'b1;
    bus.i_flush        = 1'b1;
    @(posedge clk); #1;
    expQ.delete();
    bus.i_commit_vld = 1'b0;
    bus.i_flush      = 1'b0;
    bus.i_upd_stall  = 1'b0;
    @(negedge clk);
    checkOutput("flush_update", bus.o_update, 0);
    checkOutput("flush_rdy", bus.o_commit_rdy, 1);
    @(posedge clk); #1;
    applyStimulus(32'h3500, 32'h3504, 32'h3600, 1'b0, isCond, 1'b0, 8'hDB, 1'b0, 32'h3504, 1'b1);
    waitDrain();

    // Filtered jal vs always-trained cond record
    applyStimulus(32'h4000, 32'h4004, 32'h5000, 1'b1, isJal, 1'b1, 8'hB6, 1'b1, 32'h5000, !FILT);
    applyStimulus(32'h4100, 32'h4104, 32'h5100, 1'b1, isCond, 1'b1, 8'hB6, 1'b1, 32'h5100, 1'b1);
    applyStimulus(32'h4200, 32'h4204, 32'h5200, 1'b0, isCond, 1'b0, 8'h6D, 1'b0, 32'h4204, 1'b1);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
